// File: rtl/gpp_pkg.sv
// ==== gpp_pkg : shared types and constants for the GPP APB splitter (rev 1.0) ====
`default_nettype none

package gpp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } gpp_state_e;

  localparam int GPP_TOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/gpp_tout_cnt.sv
// ==== gpp_tout_cnt : saturating ACCESS-phase watchdog, expire on the last allowed cycle (rev 1.0) ====
`default_nettype none

module gpp_tout_cnt
  import gpp_pkg::*;
#(
  parameter int TIMEOUT = GPP_TOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ rst ^ clr ^ en;
      assign expire        = 1'b0;
    end else begin : g_on
      localparam int            CW   = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt <= '0;
        end else if (en && (cnt != MAX)) begin
          cnt <= cnt + CW'(1);
        end
      end

      // Counter reads 0 in the first ACCESS cycle, so LAST marks the TIMEOUT-th cycle.
      assign expire = en && (cnt == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/gpp_apb_splitter.sv
// ==== gpp_apb_splitter : one upstream APB port fanned out to N_CH address windows (rev 1.0) ====
`default_nettype none

module gpp_apb_splitter
  import gpp_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int ADDR_W  = 12,
  parameter int CH_AW   = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = GPP_TOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_psel,
  input  logic                     s_penable,
  input  logic                     s_pwrite,
  input  logic [ADDR_W-1:0]        s_paddr,
  input  logic [DATA_W-1:0]        s_pwdata,
  output logic [DATA_W-1:0]        s_prdata,
  output logic                     s_pready,
  output logic                     s_pslverr,
  output logic [N_CH-1:0]          m_psel,
  output logic                     m_penable,
  output logic                     m_pwrite,
  output logic [CH_AW-1:0]         m_paddr,
  output logic [DATA_W-1:0]        m_pwdata,
  input  logic [N_CH*DATA_W-1:0]   m_prdata,
  input  logic [N_CH-1:0]          m_pready,
  input  logic [N_CH-1:0]          m_pslverr,
  output logic                     busy_o,
  output logic                     dec_err_stb_o,
  output logic                     tout_stb_o,
  output logic [3:0]               err_ch_o
);

  localparam logic [ADDR_W-1:0] N_CH_A = ADDR_W'(N_CH);

  gpp_state_e state, state_n;

  logic [3:0]        idx, idx_n;
  logic [N_CH-1:0]   psel_n;
  logic              penable_n, pwrite_n;
  logic [CH_AW-1:0]  paddr_n;
  logic [DATA_W-1:0] pwdata_n, prdata_n;
  logic              pready_n, pslverr_n, busy_n, dec_n, tout_n;
  logic [3:0]        err_ch_n;

  logic [ADDR_W-1:0] addr_idx;
  logic              idx_hit;
  logic [N_CH-1:0]   psel_dec;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ready, sel_err;
  logic              cnt_clr, cnt_en, tout_hit;

  assign addr_idx = s_paddr >> CH_AW;
  assign idx_hit  = addr_idx < N_CH_A;

  always_comb begin
    psel_dec = '0;
    for (int k = 0; k < N_CH; k++) begin
      psel_dec[k] = (addr_idx == ADDR_W'(k));
    end
  end

  // The registered one-hot select doubles as the return-path mux control.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (m_psel[k]) begin
        sel_rdata = sel_rdata | m_prdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_ready = |(m_pready & m_psel);
  assign sel_err   = |(m_pslverr & m_psel);

  gpp_tout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (tout_hit)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    psel_n    = m_psel;
    penable_n = m_penable;
    pwrite_n  = m_pwrite;
    paddr_n   = m_paddr;
    pwdata_n  = m_pwdata;
    pready_n  = 1'b0;
    prdata_n  = '0;
    pslverr_n = 1'b0;
    dec_n     = 1'b0;
    tout_n    = 1'b0;
    err_ch_n  = err_ch_o;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (s_psel && !s_penable) begin
          if (idx_hit) begin
            state_n  = ST_SETUP;
            idx_n    = addr_idx[3:0];
            psel_n   = psel_dec;
            pwrite_n = s_pwrite;
            paddr_n  = s_paddr[CH_AW-1:0];
            pwdata_n = s_pwdata;
          end else begin
            state_n   = ST_RESP;
            pready_n  = 1'b1;
            pslverr_n = 1'b1;
            dec_n     = 1'b1;
            err_ch_n  = addr_idx[3:0];
          end
        end
      end
      ST_SETUP: begin
        state_n   = ST_ACCESS;
        penable_n = 1'b1;
        cnt_clr   = 1'b1;
      end
      ST_ACCESS: begin
        cnt_en = 1'b1;
        if (sel_ready || tout_hit) begin
          state_n   = ST_RESP;
          pready_n  = 1'b1;
          psel_n    = '0;
          penable_n = 1'b0;
          pwrite_n  = 1'b0;
          paddr_n   = '0;
          pwdata_n  = '0;
          if (sel_ready) begin
            prdata_n  = m_pwrite ? '0 : sel_rdata;
            pslverr_n = sel_err;
            if (sel_err) err_ch_n = idx;
          end else begin
            pslverr_n = 1'b1;
            tout_n    = 1'b1;
            err_ch_n  = idx;
          end
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      m_psel        <= '0;
      m_penable     <= 1'b0;
      m_pwrite      <= 1'b0;
      m_paddr       <= '0;
      m_pwdata      <= '0;
      s_pready      <= 1'b0;
      s_prdata      <= '0;
      s_pslverr     <= 1'b0;
      busy_o        <= 1'b0;
      dec_err_stb_o <= 1'b0;
      tout_stb_o    <= 1'b0;
      err_ch_o      <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      m_psel        <= psel_n;
      m_penable     <= penable_n;
      m_pwrite      <= pwrite_n;
      m_paddr       <= paddr_n;
      m_pwdata      <= pwdata_n;
      s_pready      <= pready_n;
      s_prdata      <= prdata_n;
      s_pslverr     <= pslverr_n;
      busy_o        <= busy_n;
      dec_err_stb_o <= dec_n;
      tout_stb_o    <= tout_n;
      err_ch_o      <= err_ch_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpp_apb_splitter.sv
// ==== tb_gpp_apb_splitter : randomized transaction-level check of the APB splitter (rev 1.0) ====
`default_nettype none

module tb_gpp_apb_splitter;

  localparam int N_CH    = 3;
  localparam int ADDR_W  = 12;
  localparam int CH_AW   = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   s_psel, s_penable, s_pwrite;
  logic [ADDR_W-1:0]      s_paddr;
  logic [DATA_W-1:0]      s_pwdata;
  logic [DATA_W-1:0]      s_prdata;
  logic                   s_pready, s_pslverr;
  logic [N_CH-1:0]        m_psel;
  logic                   m_penable, m_pwrite;
  logic [CH_AW-1:0]       m_paddr;
  logic [DATA_W-1:0]      m_pwdata;
  logic [N_CH*DATA_W-1:0] m_prdata;
  logic [N_CH-1:0]        m_pready, m_pslverr;
  logic                   busy_o, dec_err_stb_o, tout_stb_o;
  logic [3:0]             err_ch_o;

  gpp_apb_splitter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .CH_AW(CH_AW), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr),
    .busy_o(busy_o), .dec_err_stb_o(dec_err_stb_o), .tout_stb_o(tout_stb_o),
    .err_ch_o(err_ch_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle, written by the stimulus side.
  bit                chk_en = 1'b0;
  logic [N_CH-1:0]   exp_psel;
  logic              exp_pen, exp_pwrite, exp_pready, exp_pslverr;
  logic              exp_busy, exp_dec, exp_tout;
  logic [CH_AW-1:0]  exp_paddr;
  logic [DATA_W-1:0] exp_pwdata, exp_prdata;
  logic [3:0]        exp_err_ch = 4'd0;

  // Fixed slave response for directed cases.
  bit                use_fixed = 1'b0;
  logic [DATA_W-1:0] fixed_rd  = '0;

  // Observations recorded by xfer for literal checks.
  logic [N_CH-1:0]   got_psel_k1;
  logic [CH_AW-1:0]  got_paddr_k1;
  logic [3:0]        got_err_ch;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_pready",  64'(s_pready),      64'(exp_pready));
      chk("s_prdata",  64'(s_prdata),      64'(exp_prdata));
      chk("s_pslverr", 64'(s_pslverr),     64'(exp_pslverr));
      chk("m_psel",    64'(m_psel),        64'(exp_psel));
      chk("m_penable", 64'(m_penable),     64'(exp_pen));
      chk("m_pwrite",  64'(m_pwrite),      64'(exp_pwrite));
      chk("m_paddr",   64'(m_paddr),       64'(exp_paddr));
      chk("m_pwdata",  64'(m_pwdata),      64'(exp_pwdata));
      chk("busy",      64'(busy_o),        64'(exp_busy));
      chk("dec_stb",   64'(dec_err_stb_o), 64'(exp_dec));
      chk("tout_stb",  64'(tout_stb_o),    64'(exp_tout));
      chk("err_ch",    64'(err_ch_o),      64'(exp_err_ch));
    end
  end

  function automatic void exp_quiet();
    exp_psel    = '0;
    exp_pen     = 1'b0;
    exp_pwrite  = 1'b0;
    exp_paddr   = '0;
    exp_pwdata  = '0;
    exp_pready  = 1'b0;
    exp_prdata  = '0;
    exp_pslverr = 1'b0;
    exp_busy    = 1'b0;
    exp_dec     = 1'b0;
    exp_tout    = 1'b0;
  endfunction

  // Random slave noise; channel act_ch (if >= 0) gets the scheduled ready bit.
  task automatic drive_slaves(input int act_ch, input bit rdy);
    for (int c = 0; c < N_CH; c++) begin
      m_prdata[c*DATA_W +: DATA_W] = $urandom;
      m_pslverr[c] = 1'($urandom_range(0, 1));
      m_pready[c]  = (c == act_ch) ? rdy : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_psel    = 1'b0;
      s_penable = 1'($urandom_range(0, 1));
      s_pwrite  = 1'($urandom_range(0, 1));
      s_paddr   = ADDR_W'($urandom);
      s_pwdata  = $urandom;
      drive_slaves(-1, 1'b0);
      exp_quiet();
    end
  endtask

  // One upstream transfer starting now (setup cycle = T, k counts cycles from T).
  // waits = downstream wait states before m_pready; rst_at >= 0 pulses rst in cycle T+rst_at.
  task automatic xfer(input logic [ADDR_W-1:0] addr, input bit wr, input logic [DATA_W-1:0] wdata,
                      input int waits, input bit drop, input int rst_at,
                      output int lat, output logic [DATA_W-1:0] rdata_o, output bit err_o);
    int idx, acc, total, kmax, r_at;
    bit miss, tout, win, resp;
    logic [DATA_W-1:0] cap_rd;
    bit cap_se;
    idx   = int'(addr >> CH_AW);
    miss  = (idx >= N_CH);
    tout  = !miss && (waits >= TIMEOUT);
    acc   = tout ? TIMEOUT : waits + 1;
    total = miss ? 1 : 2 + acc;
    r_at  = (rst_at > total) ? -1 : rst_at;
    kmax  = (r_at >= 0) ? r_at + 1 : total;
    cap_rd = '0;
    cap_se = 1'b0;
    lat    = -1;
    rdata_o = '0;
    err_o   = 1'b0;
    for (int k = 0; k <= kmax; k++) begin
      @(posedge clk); #1;
      rst = (k == r_at);
      if (r_at >= 0 && k == r_at + 1) begin
        s_psel = 1'b0; s_penable = 1'b0;
        drive_slaves(-1, 1'b0);
        exp_quiet();
        exp_err_ch = 4'd0;
      end else begin
        if (k == 0) begin
          s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr;
          s_paddr = addr; s_pwdata = wdata;
        end else begin
          s_psel    = !(drop && k >= 2);
          s_penable = !(drop && k >= 2);
          s_pwrite  = 1'($urandom_range(0, 1));
          s_paddr   = ADDR_W'($urandom);
          s_pwdata  = $urandom;
        end
        drive_slaves(miss ? -1 : idx, !miss && (k == 2 + waits));
        if (!miss && k == 2 + waits && k <= 1 + acc) begin
          if (use_fixed) begin
            m_prdata[idx*DATA_W +: DATA_W] = fixed_rd;
            m_pslverr[idx] = 1'b0;
          end
          cap_rd = m_prdata[idx*DATA_W +: DATA_W];
          cap_se = m_pslverr[idx];
        end
        win  = !miss && k >= 1 && k <= 1 + acc;
        resp = (k == total);
        exp_psel    = win ? N_CH'(1 << idx) : '0;
        exp_pen     = !miss && k >= 2 && k <= 1 + acc;
        exp_pwrite  = win && wr;
        exp_paddr   = win ? addr[CH_AW-1:0] : '0;
        exp_pwdata  = win ? wdata : '0;
        exp_pready  = resp;
        exp_pslverr = resp && (miss || tout || cap_se);
        exp_prdata  = (resp && !miss && !tout && !wr) ? cap_rd : '0;
        exp_busy    = (k >= 1);
        exp_dec     = resp && miss;
        exp_tout    = resp && tout;
        if (resp && (miss || tout || cap_se)) exp_err_ch = 4'(idx);
      end
      @(negedge clk);
      if (k == 1) begin
        got_psel_k1  = m_psel;
        got_paddr_k1 = m_paddr;
      end
      if (s_pready && lat < 0) begin
        lat        = k;
        rdata_o    = s_prdata;
        err_o      = s_pslverr;
        got_err_ch = err_ch_o;
      end
    end
    rst = 1'b0;
  endtask

  int                lat;
  logic [DATA_W-1:0] rd;
  bit                er;

  initial begin
    rst = 1'b1;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = '0; s_pwdata = '0;
    m_prdata = '0; m_pready = '0; m_pslverr = '0;
    exp_quiet();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Zero-wait read from ch1.
    use_fixed = 1'b1; fixed_rd = 32'hDEADBEEF;
    xfer(12'h404, 1'b0, 32'h0, 0, 1'b0, -1, lat, rd, er);
    chk("t1_psel_k1",  64'(got_psel_k1),  64'(3'b010));
    chk("t1_paddr_k1", 64'(got_paddr_k1), 64'h004);
    chk("t1_lat",      64'(lat),          64'd3);
    chk("t1_rdata",    64'(rd),           64'hDEADBEEF);
    chk("t1_err",      64'(er),           64'd0);

    // Write with 5 wait states (ch2 is the highest channel here).
    xfer(12'h810, 1'b1, 32'h12345678, 5, 1'b0, -1, lat, rd, er);
    chk("t2_lat",   64'(lat), 64'd8);
    chk("t2_rdata", 64'(rd),  64'd0);

    // Decode miss: idx 3 with three channels.
    xfer(12'hC00, 1'b0, 32'h0, 0, 1'b0, -1, lat, rd, er);
    chk("t3_lat",    64'(lat),        64'd1);
    chk("t3_err",    64'(er),         64'd1);
    chk("t3_err_ch", 64'(got_err_ch), 64'd3);

    // Stuck slave on ch0: abort after 16 ACCESS cycles.
    xfer(12'h000, 1'b0, 32'h0, 40, 1'b0, -1, lat, rd, er);
    chk("t4_lat",    64'(lat),        64'd18);
    chk("t4_err",    64'(er),         64'd1);
    chk("t4_err_ch", 64'(got_err_ch), 64'd0);

    // Ready on the 16th ACCESS cycle wins over the watchdog.
    fixed_rd = 32'hCAFE0005;
    xfer(12'h008, 1'b0, 32'h0, 15, 1'b0, -1, lat, rd, er);
    chk("t5_lat",   64'(lat), 64'd18);
    chk("t5_err",   64'(er),  64'd0);
    chk("t5_rdata", 64'(rd),  64'hCAFE0005);

    // Reset mid-ACCESS drops the transfer; the next read to ch2 is normal.
    xfer(12'h900, 1'b0, 32'h0, 6, 1'b0, 3, lat, rd, er);
    chk("t6_no_ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    fixed_rd = 32'h0BADF00D;
    xfer(12'h804, 1'b0, 32'h0, 0, 1'b0, -1, lat, rd, er);
    chk("t6_lat",   64'(lat), 64'd3);
    chk("t6_rdata", 64'(rd),  64'h0BADF00D);
    use_fixed = 1'b0;

    for (int i = 0; i < 160; i++) begin
      int w;
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                      : $urandom_range(0, 4);
      xfer(ADDR_W'($urandom), 1'($urandom_range(0, 1)), $urandom, w,
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1,
           lat, rd, er);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
